// File: rtl/barrel_shifter_pipe_pkg.sv
// Shared definitions for the pipelined barrel shifter.
// Provides the operation encodings, the legality check and the control
// fields that travel with every pipeline stage.
package shifter_pkg;

    localparam int unsigned MODE_W = 3;

    // Operation encodings; 101..111 are illegal and pass data through unshifted
    typedef enum logic [MODE_W-1:0] {
        MODE_SLL = 3'b000,
        MODE_SRL = 3'b001,
        MODE_SRA = 3'b010,
        MODE_ROL = 3'b011,
        MODE_ROR = 3'b100
    } mode_e;

    // Width-independent part of a stage payload; the data/amount/tag fields
    // depend on module parameters and are wrapped around this in the top
    typedef struct packed {
        logic              valid;
        logic [MODE_W-1:0] mode;
    } stage_ctl_t;

    function automatic logic is_legal_mode(input logic [MODE_W-1:0] mode);
        return mode <= MODE_ROR;
    endfunction

endpackage

// File: rtl/barrel_shifter_pipe_if.sv
// Operation/result bus of the pipelined barrel shifter.
// master: operand source and result sink (drives valid_i, data_i, s_i, mode_i,
//         tag_i, ready_i; observes ready_o, valid_o, o_y, tag_o, zero_o, err_o)
// slave:  the shifter itself (the mirror image)
interface barrel_shifter_pipe_if
    import shifter_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 4
);
    localparam int unsigned SHW = $clog2(WIDTH);

    logic              valid_i;
    logic              ready_o;
    logic [WIDTH-1:0]  data_i;
    logic [SHW-1:0]    s_i;
    logic [MODE_W-1:0] mode_i;
    logic [TAG_W-1:0]  tag_i;
    logic              valid_o;
    logic              ready_i;
    logic [WIDTH-1:0]  o_y;
    logic [TAG_W-1:0]  tag_o;
    logic              zero_o;
    logic              err_o;

    modport master (
        output valid_i, data_i, s_i, mode_i, tag_i, ready_i,
        input  ready_o, valid_o, o_y, tag_o, zero_o, err_o
    );

    modport slave (
        input  valid_i, data_i, s_i, mode_i, tag_i, ready_i,
        output ready_o, valid_o, o_y, tag_o, zero_o, err_o
    );

endinterface

// File: rtl/barrel_shifter_pipe_stage.sv
// One combinational barrel-shifter stage: moves the operand by a fixed
// SHIFT positions in the direction selected by mode when shift_en is set.
// data     in   WIDTH   operand
// shift_en in   1       apply this stage's shift
// mode     in   MODE_W  operation; illegal encodings leave the operand untouched
// result   out  WIDTH   shifted operand
module barrel_shift_stage
    import shifter_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHIFT = 1
) (
    input  logic [WIDTH-1:0]  data,
    input  logic              shift_en,
    input  logic [MODE_W-1:0] mode,
    output logic [WIDTH-1:0]  result
);

    logic [WIDTH-1:0] sra;

    // Arithmetic right shift replicates the operand's sign bit
    assign sra = WIDTH'($signed(data) >>> SHIFT);

    always_comb begin
        result = data;
        if (shift_en) begin
            case (mode)
                MODE_SLL: result = data << SHIFT;
                MODE_SRL: result = data >> SHIFT;
                MODE_SRA: result = sra;
                MODE_ROL: result = (data << SHIFT) | (data >> (WIDTH - SHIFT));
                MODE_ROR: result = (data >> SHIFT) | (data << (WIDTH - SHIFT));
                default:  result = data;
            endcase
        end
    end

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined multi-mode barrel shifter (SLL/SRL/SRA/ROL/ROR) with valid/ready
// backpressure and a pass-through tag. Stage k shifts by 2^k when amount bit k
// is set and registers the result; SHW stages, one operation per cycle.
// clk_i  in  clock, rising edge
// rst_i  in  asynchronous active-high reset, discards everything in flight
// bus    slave modport: valid_i/ready_o/data_i/s_i/mode_i/tag_i in,
//        valid_o/ready_i/o_y/tag_o/zero_o/err_o out
module barrel_shifter_pipe
    import shifter_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    barrel_shifter_pipe_if.slave bus
);

    localparam int unsigned SHW = $clog2(WIDTH);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [SHW-1:0]   s;
        logic [TAG_W-1:0] tag;
        stage_ctl_t       ctl;
    } stage_t;

    stage_t stage_d [SHW];
    stage_t stage_q [SHW];
    logic   zero_q;
    logic   err_q;
    logic   adv;

    // Whole pipeline moves in lockstep; it only stalls when a result is
    // waiting at the output and downstream refuses it
    assign adv         = !stage_q[SHW-1].ctl.valid || bus.ready_i;
    assign bus.ready_o = adv;

    // Shift stages; bubbles travel through exactly like valid entries
    for (genvar k = 0; k < SHW; k++) begin : g_stage
        stage_t           src;
        logic [WIDTH-1:0] shifted;

        if (k == 0) begin : g_in
            assign src = '{data: bus.data_i, s: bus.s_i, tag: bus.tag_i,
                           ctl: '{valid: bus.valid_i, mode: bus.mode_i}};
        end else begin : g_mid
            assign src = stage_q[k-1];
        end

        barrel_shift_stage #(
            .WIDTH (WIDTH),
            .SHIFT (1 << k)
        ) u_shift (
            .data     (src.data),
            .shift_en (src.s[k]),
            .mode     (src.ctl.mode),
            .result   (shifted)
        );

        assign stage_d[k] = '{data: shifted, s: src.s, tag: src.tag, ctl: src.ctl};
    end

    // Pipeline registers; zero/err flags are captured alongside the final stage
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int k = 0; k < SHW; k++) begin
                stage_q[k] <= '0;
            end
            zero_q <= 1'b0;
            err_q  <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < SHW; k++) begin
                stage_q[k] <= stage_d[k];
            end
            zero_q <= (stage_d[SHW-1].data == '0);
            err_q  <= !is_legal_mode(stage_d[SHW-1].ctl.mode);
        end
    end

    assign bus.valid_o = stage_q[SHW-1].ctl.valid;
    assign bus.o_y     = stage_q[SHW-1].data;
    assign bus.tag_o   = stage_q[SHW-1].tag;
    assign bus.zero_o  = zero_q;
    assign bus.err_o   = err_q;

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Self-checking bench: WIDTH=32 directed cases plus randomized traffic on
// WIDTH=8/32/64 instances, each checked against a bit-level reference model
// and an in-order expectation queue.
module tb_barrel_shifter_pipe;

    typedef struct packed {
        logic [63:0] y;
        logic [7:0]  tag;
        logic        zero;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    barrel_shifter_pipe_if #(.WIDTH(32), .TAG_W(4)) ba ();
    barrel_shifter_pipe_if #(.WIDTH(8),  .TAG_W(4)) bb ();
    barrel_shifter_pipe_if #(.WIDTH(64), .TAG_W(4)) bc ();

    barrel_shifter_pipe #(.WIDTH(32), .TAG_W(4)) u_a (.clk_i(clk), .rst_i(rst), .bus(ba.slave));
    barrel_shifter_pipe #(.WIDTH(8),  .TAG_W(4)) u_b (.clk_i(clk), .rst_i(rst), .bus(bb.slave));
    barrel_shifter_pipe #(.WIDTH(64), .TAG_W(4)) u_c (.clk_i(clk), .rst_i(rst), .bus(bc.slave));

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: each result bit picked straight from its source position
    function automatic exp_t model(input logic [63:0] d, input int s, input int m,
                                   input logic [7:0] tag, input int w);
        exp_t        e;
        logic [63:0] y = '0;
        for (int i = 0; i < w; i++) begin
            case (m)
                0:       y[i] = (i >= s)    ? d[i-s] : 1'b0;
                1:       y[i] = (i + s < w) ? d[i+s] : 1'b0;
                2:       y[i] = (i + s < w) ? d[i+s] : d[w-1];
                3:       y[i] = d[(i - s + w) % w];
                4:       y[i] = d[(i + s) % w];
                default: y[i] = d[i];
            endcase
        end
        e.y    = y;
        e.tag  = tag;
        e.zero = (y == 64'd0);
        e.err  = (m > 4);
        return e;
    endfunction

    exp_t        qa[$], qb[$], qc[$];
    logic        hold_a = 0, hold_b = 0, hold_c = 0;
    logic [75:0] snap_a, snap_b, snap_c;
    logic        took_a = 0, took_b = 0, took_c = 0;
    int          acc_a = 0, acc_b = 0, acc_c = 0;

    // Compare process, instance a (WIDTH=32)
    always @(negedge clk) begin
        logic [75:0] cur;
        exp_t        e;
        cur = {1'b1, 1'(ba.valid_o), 64'(ba.o_y), 8'(ba.tag_o), ba.zero_o, ba.err_o};
        if (rst) begin
            qa.delete(); hold_a = 1'b0; took_a = 1'b0;
        end else begin
            check("a ready_o", 128'(ba.ready_o), 128'(!ba.valid_o || ba.ready_i));
            if (hold_a) check("a held output", 128'(cur), 128'(snap_a));
            took_a = ba.valid_i && ba.ready_o;
            if (took_a) begin
                qa.push_back(model(64'(ba.data_i), int'(ba.s_i), int'(ba.mode_i), 8'(ba.tag_i), 32));
                acc_a++;
            end
            if (ba.valid_o && ba.ready_i) begin
                n_tests++;
                if (qa.size() == 0) begin
                    n_fail++;
                    $display("FAIL a extra result: got y=%h tag=%0d, expected no result", ba.o_y, ba.tag_o);
                end else begin
                    e = qa.pop_front();
                    n_tests--;
                    check("a result", 128'({64'(ba.o_y), 8'(ba.tag_o), ba.zero_o, ba.err_o}), 128'(e));
                end
            end
            hold_a = ba.valid_o && !ba.ready_i;
            snap_a = cur;
        end
    end

    // Compare process, instance b (WIDTH=8)
    always @(negedge clk) begin
        logic [75:0] cur;
        exp_t        e;
        cur = {1'b1, 1'(bb.valid_o), 64'(bb.o_y), 8'(bb.tag_o), bb.zero_o, bb.err_o};
        if (rst) begin
            qb.delete(); hold_b = 1'b0; took_b = 1'b0;
        end else begin
            check("b ready_o", 128'(bb.ready_o), 128'(!bb.valid_o || bb.ready_i));
            if (hold_b) check("b held output", 128'(cur), 128'(snap_b));
            took_b = bb.valid_i && bb.ready_o;
            if (took_b) begin
                qb.push_back(model(64'(bb.data_i), int'(bb.s_i), int'(bb.mode_i), 8'(bb.tag_i), 8));
                acc_b++;
            end
            if (bb.valid_o && bb.ready_i) begin
                n_tests++;
                if (qb.size() == 0) begin
                    n_fail++;
                    $display("FAIL b extra result: got y=%h tag=%0d, expected no result", bb.o_y, bb.tag_o);
                end else begin
                    e = qb.pop_front();
                    n_tests--;
                    check("b result", 128'({64'(bb.o_y), 8'(bb.tag_o), bb.zero_o, bb.err_o}), 128'(e));
                end
            end
            hold_b = bb.valid_o && !bb.ready_i;
            snap_b = cur;
        end
    end

    // Compare process, instance c (WIDTH=64)
    always @(negedge clk) begin
        logic [75:0] cur;
        exp_t        e;
        cur = {1'b1, 1'(bc.valid_o), 64'(bc.o_y), 8'(bc.tag_o), bc.zero_o, bc.err_o};
        if (rst) begin
            qc.delete(); hold_c = 1'b0; took_c = 1'b0;
        end else begin
            check("c ready_o", 128'(bc.ready_o), 128'(!bc.valid_o || bc.ready_i));
            if (hold_c) check("c held output", 128'(cur), 128'(snap_c));
            took_c = bc.valid_i && bc.ready_o;
            if (took_c) begin
                qc.push_back(model(64'(bc.data_i), int'(bc.s_i), int'(bc.mode_i), 8'(bc.tag_i), 64));
                acc_c++;
            end
            if (bc.valid_o && bc.ready_i) begin
                n_tests++;
                if (qc.size() == 0) begin
                    n_fail++;
                    $display("FAIL c extra result: got y=%h tag=%0d, expected no result", bc.o_y, bc.tag_o);
                end else begin
                    e = qc.pop_front();
                    n_tests--;
                    check("c result", 128'({64'(bc.o_y), 8'(bc.tag_o), bc.zero_o, bc.err_o}), 128'(e));
                end
            end
            hold_c = bc.valid_o && !bc.ready_i;
            snap_c = cur;
        end
    end

    // Present one op on instance a and wait (bounded) until it is taken
    task automatic send32(input logic [31:0] d, input int s, input int m, input int tag);
        int n = 0;
        ba.valid_i = 1'b1;
        ba.data_i  = d;
        ba.s_i     = 5'(s);
        ba.mode_i  = 3'(m);
        ba.tag_i   = 4'(tag);
        do begin
            @(negedge clk);
            n++;
        end while (!ba.ready_o && n < 50);
        check("send accepted", 128'(ba.ready_o), 128'(1));
        @(posedge clk);
        #1;
    endtask

    // Single op with literal expectation; latency counted in cycles from the
    // accepting cycle to the first cycle showing valid_o
    task automatic run32(input string name, input logic [31:0] d, input int s, input int m,
                         input int tag, input logic [31:0] ey, input logic ez, input logic ee);
        int lat = 0;
        send32(d, s, m, tag);
        ba.valid_i = 1'b0;
        do begin
            @(negedge clk);
            lat++;
        end while (!ba.valid_o && lat < 20);
        check({name, " latency"}, 128'(lat), 128'(5));
        check({name, " result"}, 128'({ba.o_y, ba.tag_o, ba.zero_o, ba.err_o}),
              128'({ey, 4'(tag), ez, ee}));
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        ba.valid_i = 0; ba.ready_i = 1; ba.data_i = '0; ba.s_i = '0; ba.mode_i = '0; ba.tag_i = '0;
        bb.valid_i = 0; bb.ready_i = 1; bb.data_i = '0; bb.s_i = '0; bb.mode_i = '0; bb.tag_i = '0;
        bc.valid_i = 0; bc.ready_i = 1; bc.data_i = '0; bc.s_i = '0; bc.mode_i = '0; bc.tag_i = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int   tags[$];
        int   stale;
        int   oc;
        idle_all();
        #1 rst = 1'b1;
        #2;
        check("rst a valid_o", 128'(ba.valid_o), 128'(0));
        check("rst a ready_o", 128'(ba.ready_o), 128'(1));
        check("rst a o_y/tag", 128'({ba.o_y, ba.tag_o}), 128'(0));
        check("rst b valid_o", 128'(bb.valid_o), 128'(0));
        check("rst c valid_o", 128'(bc.valid_o), 128'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed WIDTH=32 cases
        run32("sll",         32'h0000_00F1,  4, 0, 1, 32'h0000_0F10, 1'b0, 1'b0);
        run32("sra",         32'h8000_0010,  4, 2, 2, 32'hF800_0001, 1'b0, 1'b0);
        run32("srl",         32'h8000_0010,  4, 1, 3, 32'h0800_0001, 1'b0, 1'b0);
        run32("ror",         32'h1234_5678,  8, 4, 4, 32'h7812_3456, 1'b0, 1'b0);
        run32("rol",         32'h8000_0001, 31, 3, 5, 32'hC000_0000, 1'b0, 1'b0);
        run32("sll to zero", 32'h8000_0000,  1, 0, 6, 32'h0000_0000, 1'b1, 1'b0);
        run32("illegal",     32'hDEAD_BEEF,  3, 7, 7, 32'hDEAD_BEEF, 1'b0, 1'b1);
        run32("legal after", 32'h0000_0010,  0, 1, 8, 32'h0000_0010, 1'b0, 1'b0);
        run32("sra s0",      32'h8000_0000,  0, 2, 9, 32'h8000_0000, 1'b0, 1'b0);

        // Burst of 8 with downstream stalled in output cycles 3..6
        fork
            begin
                for (int i = 0; i < 8; i++) send32($urandom, int'($urandom_range(0, 31)), int'($urandom_range(0, 4)), i);
                ba.valid_i = 1'b0;
            end
            begin
                oc = -1;
                for (int cyc = 0; cyc < 80 && tags.size() < 8; cyc++) begin
                    @(negedge clk);
                    if (oc < 0 && ba.valid_o) oc = 0;
                    if (oc >= 3 && oc <= 6) check("burst ready_o stalled", 128'(ba.ready_o), 128'(0));
                    if (ba.valid_o && ba.ready_i) tags.push_back(int'(ba.tag_o));
                    @(posedge clk);
                    #1;
                    if (oc >= 0) oc++;
                    ba.ready_i = !(oc >= 3 && oc <= 6);
                end
            end
        join
        ba.ready_i = 1'b1;
        check("burst count", 128'(tags.size()), 128'(8));
        for (int i = 0; i < tags.size(); i++) check("burst tag order", 128'(tags[i]), 128'(i));

        // Reset with three ops in flight and the head stalled at the output
        ba.ready_i = 1'b0;
        send32(32'h0000_0003, 1, 0, 10);
        send32(32'h0000_0005, 2, 0, 11);
        send32(32'h0000_0007, 3, 0, 12);
        ba.valid_i = 1'b0;
        for (int n = 0; n < 20 && !ba.valid_o; n++) @(negedge clk);
        check("pre-reset valid_o", 128'(ba.valid_o), 128'(1));
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("async rst valid_o", 128'(ba.valid_o), 128'(0));
        check("async rst outputs", 128'({ba.o_y, ba.tag_o, ba.zero_o, ba.err_o}), 128'(0));
        check("async rst ready_o", 128'(ba.ready_o), 128'(1));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        ba.ready_i = 1'b1;
        stale = 0;
        repeat (15) begin
            @(negedge clk);
            if (ba.valid_o) stale++;
        end
        check("no stale after reset", 128'(stale), 128'(0));
        @(posedge clk);
        #1;
        run32("post reset ror", 32'hA5A5_0F0F, 4, 4, 13, 32'hFA5A_50F0, 1'b0, 1'b0);

        // Randomized traffic on all widths with random backpressure
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk);
            #1;
            if (took_a || !ba.valid_i) begin
                ba.valid_i = ($urandom_range(0, 3) != 0);
                ba.data_i  = $urandom;
                ba.s_i     = 5'($urandom);
                ba.mode_i  = 3'($urandom);
                ba.tag_i   = 4'($urandom);
            end
            if (took_b || !bb.valid_i) begin
                bb.valid_i = ($urandom_range(0, 3) != 0);
                bb.data_i  = 8'($urandom);
                bb.s_i     = 3'($urandom);
                bb.mode_i  = 3'($urandom);
                bb.tag_i   = 4'($urandom);
            end
            if (took_c || !bc.valid_i) begin
                bc.valid_i = ($urandom_range(0, 3) != 0);
                bc.data_i  = {$urandom, $urandom};
                bc.s_i     = 6'($urandom);
                bc.mode_i  = 3'($urandom);
                bc.tag_i   = 4'($urandom);
            end
            ba.ready_i = ($urandom_range(0, 3) != 0);
            bb.ready_i = ($urandom_range(0, 3) != 0);
            bc.ready_i = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk);
        #1;
        idle_all();
        repeat (20) @(posedge clk);
        #1;
        check("a drained", 128'(qa.size()), 128'(0));
        check("b drained", 128'(qb.size()), 128'(0));
        check("c drained", 128'(qc.size()), 128'(0));
        check("a random traffic", 128'(acc_a > 1000), 128'(1));
        check("b random traffic", 128'(acc_b > 1000), 128'(1));
        check("c random traffic", 128'(acc_c > 1000), 128'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
